// File: rtl/span_pkg.sv
// Shared types and constants for the span position loader slice.
// Build option: SPAN_LOADER_SAT_EN (clamp instead of wrap on position overflow).
package span_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int POS_W     = 16;
    localparam int MAT_W     = 8;
    localparam int QTY_W     = POS_W - 1;
    localparam int CNT_W     = 16;

    localparam logic [MAT_W-1:0]        MAT_EMPTY = 8'hFF;
    localparam logic signed [POS_W-1:0] POS_MAX   = 16'sd32767;
    localparam logic signed [POS_W-1:0] POS_MIN   = -16'sd32767;

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH, CLEAR} ldr_state_t;

    // Signed delta for one trade; a 15-bit quantity always fits after negation.
    function automatic logic signed [POS_W-1:0] qty_delta(input logic [QTY_W-1:0] qty,
                                                          input logic sell);
        logic signed [POS_W-1:0] mag;
        mag = signed'({1'b0, qty});
        return sell ? -mag : mag;
    endfunction
endpackage

// File: rtl/span_position_loader_if.sv
// Trade beat stream into the span position loader (valid/ready handshake).
interface span_position_loader_if;
    import span_pkg::*;

    logic              trd_valid;
    logic              trd_ready;
    logic [SLOT_W-1:0] trd_slot;
    logic [MAT_W-1:0]  trd_maturity;
    logic [QTY_W-1:0]  trd_qty;
    logic              trd_sell;
    logic              trd_last;

    modport master (
        output trd_valid, trd_slot, trd_maturity, trd_qty, trd_sell, trd_last,
        input  trd_ready
    );

    modport slave (
        input  trd_valid, trd_slot, trd_maturity, trd_qty, trd_sell, trd_last,
        output trd_ready
    );
endinterface

// File: rtl/span_sat_add.sv
// Signed 16b + 16b adder with overflow flag; legal range excludes -32768.
// SPAN_LOADER_SAT_EN selects clamping, otherwise the low 16 bits wrap.
module span_sat_add
    import span_pkg::*;
(
    input  logic signed [POS_W-1:0] a,
    input  logic signed [POS_W-1:0] b,
    output logic signed [POS_W-1:0] sum,
    output logic                    ovf
);
    localparam logic signed [POS_W:0] WIDE_MAX = {POS_MAX[POS_W-1], POS_MAX};
    localparam logic signed [POS_W:0] WIDE_MIN = {POS_MIN[POS_W-1], POS_MIN};

    logic signed [POS_W:0] wide;

    always_comb begin
        wide = {a[POS_W-1], a} + {b[POS_W-1], b};
        ovf  = (wide > WIDE_MAX) || (wide < WIDE_MIN);
`ifdef SPAN_LOADER_SAT_EN
        if (wide > WIDE_MAX) begin
            sum = POS_MAX;
        end else if (wide < WIDE_MIN) begin
            sum = POS_MIN;
        end else begin
            sum = wide[POS_W-1:0];
        end
`else
        sum = wide[POS_W-1:0];
`endif
    end
endmodule

// File: rtl/span_position_loader.sv
// Nets a trade stream into 8 contract slots and publishes a frozen snapshot.
// Build option: SPAN_LOADER_SAT_EN (see span_sat_add).
module span_position_loader
    import span_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    span_position_loader_if.slave            trd,
    input  logic                             snap_release,
    output logic [NUM_SLOTS-1:0][POS_W-1:0]  position,
    output logic [NUM_SLOTS-1:0][MAT_W-1:0]  maturity,
    output logic                             snap_valid,
    output logic [CNT_W-1:0]                 trade_count,
    output logic                             err_maturity,
    output logic                             err_ovf
);
    ldr_state_t              state_reg, state_next;
    logic [SLOT_W-1:0]       clr_idx_reg, clr_idx_next;
    logic [POS_W-1:0]        pos_reg [NUM_SLOTS];
    logic [MAT_W-1:0]        mat_reg [NUM_SLOTS];
    logic [CNT_W-1:0]        count_reg;
    logic                    err_mat_reg, err_ovf_reg;

    logic                    accept, mat_bad;
    logic signed [POS_W-1:0] cur_pos, delta, add_sum;
    logic                    add_ovf;
    logic [MAT_W-1:0]        cur_mat;
    logic                    wr_en;
    logic [SLOT_W-1:0]       wr_idx;
    logic [POS_W-1:0]        wr_pos;
    logic [MAT_W-1:0]        wr_mat;

    assign trd.trd_ready = reset && (state_reg == IDLE || state_reg == ACCUM);
    assign accept        = trd.trd_valid && trd.trd_ready;
    assign cur_pos       = signed'(pos_reg[trd.trd_slot]);
    assign cur_mat       = mat_reg[trd.trd_slot];
    assign delta         = qty_delta(trd.trd_qty, trd.trd_sell);
    assign mat_bad       = (cur_mat != MAT_EMPTY) && (cur_mat != trd.trd_maturity);

    span_sat_add u_add (
        .a   (cur_pos),
        .b   (delta),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // One write per cycle: either a netted trade or one slot of the CLEAR sweep.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        wr_en        = 1'b0;
        wr_idx       = trd.trd_slot;
        wr_pos       = add_sum;
        wr_mat       = trd.trd_maturity;
        unique case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    wr_en      = !mat_bad;
                    state_next = trd.trd_last ? PUBLISH : ACCUM;
                end
            end
            PUBLISH: begin
                if (snap_release) state_next = CLEAR;
            end
            CLEAR: begin
                wr_en        = 1'b1;
                wr_idx       = clr_idx_reg;
                wr_pos       = '0;
                wr_mat       = MAT_EMPTY;
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == SLOT_W'(NUM_SLOTS - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clr_idx_reg <= '0;
            count_reg   <= '0;
            err_mat_reg <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
            if (state_reg == CLEAR && state_next == IDLE) begin
                count_reg <= '0;
            end else if (accept && count_reg != {CNT_W{1'b1}}) begin
                count_reg <= count_reg + 1'b1;
            end
            if (accept && mat_bad)             err_mat_reg <= 1'b1;
            if (accept && !mat_bad && add_ovf) err_ovf_reg <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!reset) begin
                    pos_reg[gi] <= '0;
                    mat_reg[gi] <= MAT_EMPTY;
                end else if (wr_en && wr_idx == SLOT_W'(gi)) begin
                    pos_reg[gi] <= wr_pos;
                    mat_reg[gi] <= wr_mat;
                end
            end
            assign position[gi] = pos_reg[gi];
            assign maturity[gi] = mat_reg[gi];
        end
    endgenerate

    assign snap_valid   = (state_reg == PUBLISH);
    assign trade_count  = count_reg;
    assign err_maturity = err_mat_reg;
    assign err_ovf      = err_ovf_reg;
endmodule

// File: tb/tb_span_position_loader.sv
// Directed self-checking bench for span_position_loader.
module tb_span_position_loader;
    import span_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic snap_release;
    logic [NUM_SLOTS-1:0][POS_W-1:0] position;
    logic [NUM_SLOTS-1:0][MAT_W-1:0] maturity;
    logic snap_valid;
    logic [CNT_W-1:0] trade_count;
    logic err_maturity, err_ovf;
    int checks = 0;
    int errors = 0;

    span_position_loader_if trd_if();

    span_position_loader dut (
        .clk          (clk),
        .reset        (reset),
        .trd          (trd_if),
        .snap_release (snap_release),
        .position     (position),
        .maturity     (maturity),
        .snap_valid   (snap_valid),
        .trade_count  (trade_count),
        .err_maturity (err_maturity),
        .err_ovf      (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            check($sformatf("%s_pos%0d", tag, i), 32'(position[i]), 32'h0);
            check($sformatf("%s_mat%0d", tag, i), 32'(maturity[i]), 32'hFF);
        end
    endtask

    // Present one beat, wait (bounded) for ready, let it be accepted, drop valid.
    task automatic beat(input string tag, input int slot, input int mat, input int qty,
                        input logic sell, input logic last);
        int n = 0;
        trd_if.trd_valid    = 1'b1;
        trd_if.trd_slot     = SLOT_W'(slot);
        trd_if.trd_maturity = MAT_W'(mat);
        trd_if.trd_qty      = QTY_W'(qty);
        trd_if.trd_sell     = sell;
        trd_if.trd_last     = last;
        while (!trd_if.trd_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(trd_if.trd_ready), 32'h1);
        tick();
        trd_if.trd_valid = 1'b0;
        trd_if.trd_last  = 1'b0;
        $display("beat %s slot=%0d mat=%0d qty=%0d sell=%0b last=%0b count=%0d",
                 tag, slot, mat, qty, sell, last, trade_count);
    endtask

    task automatic release_and_clear(input string tag);
        snap_release = 1'b1;
        tick();
        snap_release = 1'b0;
        check({tag, "_snapv_drop"}, 32'(snap_valid), 32'h0);
        repeat (7) tick();
        check({tag, "_ready_in_clear"}, 32'(trd_if.trd_ready), 32'h0);
        tick();
        check({tag, "_ready_idle"}, 32'(trd_if.trd_ready), 32'h1);
        check({tag, "_count_idle"}, 32'(trade_count), 32'h0);
        check_empty({tag, "_cleared"});
        $display("release %s done", tag);
    endtask

    initial begin
        reset = 1'b0;
        snap_release = 1'b0;
        trd_if.trd_valid = 1'b0;
        trd_if.trd_slot = '0;
        trd_if.trd_maturity = '0;
        trd_if.trd_qty = '0;
        trd_if.trd_sell = 1'b0;
        trd_if.trd_last = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(trd_if.trd_ready), 32'h0);
        check("rst_snapv", 32'(snap_valid), 32'h0);
        check("rst_count", 32'(trade_count), 32'h0);
        check("rst_errm", 32'(err_maturity), 32'h0);
        check("rst_erro", 32'(err_ovf), 32'h0);
        check_empty("rst");
        reset = 1'b1;
        tick();
        check("post_rst_ready", 32'(trd_if.trd_ready), 32'h1);

        // 1: netting across two slots
        beat("t1a", 0, 3, 5, 1'b0, 1'b0);
        beat("t1b", 0, 3, 2, 1'b1, 1'b0);
        beat("t1c", 1, 7, 4, 1'b0, 1'b1);
        check("t1_pos0", 32'(position[0]), 32'h3);
        check("t1_pos1", 32'(position[1]), 32'h4);
        check("t1_mat0", 32'(maturity[0]), 32'h3);
        check("t1_mat1", 32'(maturity[1]), 32'h7);
        for (int i = 2; i < NUM_SLOTS; i++)
            check($sformatf("t1_mat%0d", i), 32'(maturity[i]), 32'hFF);
        check("t1_snapv", 32'(snap_valid), 32'h1);
        check("t1_count", 32'(trade_count), 32'h3);
        check("t1_ready", 32'(trd_if.trd_ready), 32'h0);
        release_and_clear("t1");

        // 2: single short trade, snapshot held
        beat("t2", 2, 4, 10, 1'b1, 1'b1);
        check("t2_pos2", 32'(position[2]), 32'hFFF6);
        trd_if.trd_valid = 1'b1;
        repeat (3) tick();
        check("t2_ready_held", 32'(trd_if.trd_ready), 32'h0);
        check("t2_snapv_held", 32'(snap_valid), 32'h1);
        check("t2_count_held", 32'(trade_count), 32'h1);
        trd_if.trd_valid = 1'b0;
        release_and_clear("t2");

        // 3: maturity mismatch drops the beat; netting back to zero keeps maturity
        beat("t3a", 0, 3, 1, 1'b0, 1'b0);
        beat("t3b", 0, 5, 1, 1'b0, 1'b0);
        check("t3_pos0", 32'(position[0]), 32'h1);
        check("t3_mat0", 32'(maturity[0]), 32'h3);
        check("t3_errm", 32'(err_maturity), 32'h1);
        check("t3_count", 32'(trade_count), 32'h2);
        beat("t3c", 0, 3, 1, 1'b1, 1'b1);
        check("t3_pos0_zero", 32'(position[0]), 32'h0);
        check("t3_mat0_kept", 32'(maturity[0]), 32'h3);
        release_and_clear("t3");
        check("t3_errm_sticky", 32'(err_maturity), 32'h1);

        // 4: overflow
        beat("t4a", 4, 1, 32767, 1'b0, 1'b0);
        check("t4_erro_pre", 32'(err_ovf), 32'h0);
        beat("t4b", 4, 1, 1, 1'b0, 1'b1);
        check("t4_erro", 32'(err_ovf), 32'h1);
`ifdef SPAN_LOADER_SAT_EN
        check("t4_pos4", 32'(position[4]), 32'h7FFF);
`else
        check("t4_pos4", 32'(position[4]), 32'h8000);
`endif
        release_and_clear("t4");

        // 5: reset mid-accumulation
        beat("t5a", 5, 2, 7, 1'b0, 1'b0);
        beat("t5b", 6, 2, 9, 1'b1, 1'b0);
        beat("t5c", 5, 2, 1, 1'b0, 1'b0);
        check("t5_pos5_pre", 32'(position[5]), 32'h8);
        reset = 1'b0;
        tick();
        check("t5_ready_rst", 32'(trd_if.trd_ready), 32'h0);
        check("t5_count", 32'(trade_count), 32'h0);
        check("t5_errm", 32'(err_maturity), 32'h0);
        check("t5_erro", 32'(err_ovf), 32'h0);
        check("t5_snapv", 32'(snap_valid), 32'h0);
        check_empty("t5");
        reset = 1'b1;
        tick();
        check("t5_ready_idle", 32'(trd_if.trd_ready), 32'h1);
        $display("reset t5 done");

        // 6: valid held high; release in ACCUM ignored; beat 3 stalls through CLEAR
        beat("t6a", 3, 2, 1, 1'b0, 1'b0);
        snap_release = 1'b1;
        tick();
        snap_release = 1'b0;
        check("t6_accum_ready", 32'(trd_if.trd_ready), 32'h1);
        check("t6_accum_snapv", 32'(snap_valid), 32'h0);
        trd_if.trd_valid    = 1'b1;
        trd_if.trd_slot     = 3'd3;
        trd_if.trd_maturity = 8'd2;
        trd_if.trd_qty      = 15'd1;
        trd_if.trd_sell     = 1'b0;
        trd_if.trd_last     = 1'b1;
        tick();
        trd_if.trd_last = 1'b0;
        check("t6_snapv", 32'(snap_valid), 32'h1);
        check("t6_count2", 32'(trade_count), 32'h2);
        check("t6_pos3", 32'(position[3]), 32'h2);
        repeat (3) tick();
        check("t6_count_hold", 32'(trade_count), 32'h2);
        check("t6_pos3_hold", 32'(position[3]), 32'h2);
        release_and_clear("t6");
        tick();
        trd_if.trd_valid = 1'b0;
        check("t6_beat3_count", 32'(trade_count), 32'h1);
        check("t6_beat3_pos3", 32'(position[3]), 32'h1);
        $display("beat t6c accepted after clear count=%0d", trade_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
